stos_pc: RTL

Hardware return-address stack feeding the program counter. Pushes a return frame on CALL or interrupt acceptance, pops it on RET/RETI, and drives the PC's stack-jump inputs (`skok_pc_stos`, `adres_skok_pc_stos`, `reti_int_en`) in the same cycle as the pop request. Sits between the instruction decoder/interrupt logic and `pc`; the decoder ORs `skok_pc_stos` into the PC's `skok_pc`.

---
 rtl/stos_pc_pkg.sv | 24 ++
 rtl/stos_pc_if.sv | 40 ++++
 rtl/stos_pc_mem.sv | 36 +++
 rtl/stos_pc.sv | 116 +++++++++++
 4 files changed

// File: rtl/stos_pc_pkg.sv
// -----------------------------------------------------------------------------
// stos_pkg
// Shared types and defaults for the hardware return-address stack.
//   PKG_W       : default address width (matches the PC width)
//   PKG_D       : default stack depth in frames (power of two, >= 2)
//   typ_ramki_t : frame type, CALL or interrupt
//   ramka_t     : packed frame {typ, adres}; typ sits in the MSB
// -----------------------------------------------------------------------------
package stos_pkg;

   localparam int PKG_W = 8;
   localparam int PKG_D = 8;

   typedef enum logic {
      RAMKA_CALL = 1'b0,
      RAMKA_INT  = 1'b1
   } typ_ramki_t;

   typedef struct packed {
      typ_ramki_t         typ;
      logic [PKG_W-1:0]   adres;
   } ramka_t;

endpackage

// File: rtl/stos_pc_if.sv
// -----------------------------------------------------------------------------
// stos_pc_if
// Request/response bundle between the decoder/interrupt logic, the stack and
// the PC.
//   slave  : the stack side (stos_pc)
//   master : the decoder / PC side
// Requests : ID_rst, call, int_ack, pc_in, ret, reti
// Responses: adres_skok_pc_stos, skok_pc_stos, reti_int_en,
//            pusty, pelny, glebokosc, blad
// -----------------------------------------------------------------------------
interface stos_pc_if #(
   parameter int W = 8,
   parameter int D = 8
);
   logic                   ID_rst;
   logic                   call;
   logic                   int_ack;
   logic [W-1:0]           pc_in;
   logic                   ret;
   logic                   reti;
   logic [W-1:0]           adres_skok_pc_stos;
   logic                   skok_pc_stos;
   logic                   reti_int_en;
   logic                   pusty;
   logic                   pelny;
   logic [$clog2(D):0]     glebokosc;
   logic                   blad;

   modport slave (
      input  ID_rst, call, int_ack, pc_in, ret, reti,
      output adres_skok_pc_stos, skok_pc_stos, reti_int_en,
             pusty, pelny, glebokosc, blad
   );

   modport master (
      output ID_rst, call, int_ack, pc_in, ret, reti,
      input  adres_skok_pc_stos, skok_pc_stos, reti_int_en,
             pusty, pelny, glebokosc, blad
   );
endinterface

// File: rtl/stos_pc_mem.sv
// -----------------------------------------------------------------------------
// stos_mem
// D x (W+1) frame storage: one synchronous write port, one combinational read
// port. Contents are intentionally not reset.
//   clk        : clock
//   i_we       : write enable
//   i_wr_idx   : write slot
//   i_wr_data  : frame to write {typ, adres}
//   i_rd_idx   : read slot (top of stack, sp-1)
//   o_rd_data  : frame at i_rd_idx
// -----------------------------------------------------------------------------
module stos_mem #(
   parameter int W  = 8,
   parameter int D  = 8,
   parameter int AW = $clog2(D)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_wr_idx,
   input  logic [W:0]    i_wr_data,
   input  logic [AW-1:0] i_rd_idx,
   output logic [W:0]    o_rd_data
);

   logic [W:0] r_ramki [D];

   // Frame array write port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_ramki[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_ramki[i_rd_idx];

endmodule

// File: rtl/stos_pc.sv
// -----------------------------------------------------------------------------
// stos_pc
// Hardware return-address stack feeding the PC. Pushes on CALL / interrupt
// acceptance, pops on RET / RETI and presents the popped frame to the PC in
// the same cycle as the pop request.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stos_pc_if.slave (requests in, stack-jump outputs and flags out)
// -----------------------------------------------------------------------------
module stos_pc
   import stos_pkg::*;
#(
   parameter int W = PKG_W,
   parameter int D = PKG_D
) (
   input  logic     clk,
   input  logic     rst_n,
   stos_pc_if.slave bus
);

   localparam int             AW      = $clog2(D);
   localparam logic [AW:0]    SP_ZERO = '0;
   localparam logic [AW:0]    SP_ONE  = (AW+1)'(1);
   localparam logic [AW:0]    SP_FULL = (AW+1)'(D);

   logic [AW:0]   r_sp;
   logic          r_blad;

   logic [AW:0]   w_sp_nxt;
   logic          w_we;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_top_idx;
   logic [W:0]    w_top;
   logic [W:0]    w_wr_data;
   logic          w_push_req, w_pop_req, w_push_ill, w_pop_ill;
   logic          w_empty, w_full, w_pop_ok, w_typ_err, w_err;

   assign w_empty    = (r_sp == SP_ZERO);
   assign w_full     = (r_sp == SP_FULL);
   assign w_push_req = bus.call | bus.int_ack;
   assign w_pop_req  = bus.ret | bus.reti;
   assign w_push_ill = bus.call & bus.int_ack;
   assign w_pop_ill  = bus.ret & bus.reti;
   assign w_pop_ok   = w_pop_req & ~w_pop_ill & ~w_empty;

   // sp-1 wraps to D-1 when empty; the read is masked out in that case.
   assign w_top_idx  = AW'(r_sp - SP_ONE);
   // On call+int_ack together the interrupt frame wins, so typ = int_ack.
   assign w_wr_data  = {bus.int_ack, bus.pc_in};

   assign w_typ_err  = w_pop_ok &
                       ((bus.ret  & (w_top[W] == RAMKA_INT)) |
                        (bus.reti & (w_top[W] == RAMKA_CALL)));
   assign w_err      = w_push_ill | w_pop_ill |
                       (w_push_req & w_full & ~w_pop_ok) |
                       (w_pop_req & w_empty) |
                       w_typ_err;

   // Next pointer and write port: push+pop overwrites the top in place.
   always_comb begin
      w_sp_nxt = r_sp;
      w_we     = 1'b0;
      w_wr_idx = r_sp[AW-1:0];
      if (w_pop_ok && w_push_req) begin
         w_we     = ~bus.ID_rst;
         w_wr_idx = w_top_idx;
      end else if (w_push_req && !w_full) begin
         w_we     = ~bus.ID_rst;
         w_sp_nxt = r_sp + SP_ONE;
      end else if (w_pop_ok) begin
         w_sp_nxt = r_sp - SP_ONE;
      end else begin
         w_sp_nxt = r_sp;
      end
   end

   // Stack pointer and sticky error flag; ID_rst overrides every request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp   <= SP_ZERO;
         r_blad <= 1'b0;
      end else if (bus.ID_rst) begin
         r_sp   <= SP_ZERO;
         r_blad <= 1'b0;
      end else begin
         r_sp   <= w_sp_nxt;
         r_blad <= r_blad | w_err;
      end
   end

   stos_mem #(.W(W), .D(D)) u_mem (
      .clk       (clk),
      .i_we      (w_we),
      .i_wr_idx  (w_wr_idx),
      .i_wr_data (w_wr_data),
      .i_rd_idx  (w_top_idx),
      .o_rd_data (w_top)
   );

   // Same-cycle outputs to the PC, plus pointer-derived flags.
   always_comb begin
      bus.skok_pc_stos       = w_pop_ok;
      bus.reti_int_en        = w_pop_ok & w_top[W];
      bus.adres_skok_pc_stos = '0;
      if (!w_empty) begin
         bus.adres_skok_pc_stos = w_top[W-1:0];
      end else begin
         bus.adres_skok_pc_stos = '0;
      end
      bus.pusty     = w_empty;
      bus.pelny     = w_full;
      bus.glebokosc = r_sp;
      bus.blad      = r_blad;
   end

endmodule
